comp_share_arb: RTL
===================

# comp_share_arb

Shares one WIDTH-bit magnitude comparator among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one requester at a time, latches its operands and runs a single registered compare. The result (one-hot G/E/L plus the requester ID) is returned on a response channel with its own valid/ready handshake. The block sits between the comparator-based datapath clients and the comparator equations, and serialises all compare traffic.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 4: operand width in bits, unsigned.
- IDW, default 2: ID width, equal to clog2(N_REQ).
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- req_valid  in  N_REQ: bit i set means requester i presents a pair.
- req_a  in  N_REQ*WIDTH: operand A of requester i is at bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH: operand B, same packing as req_a.
- req_ready  out  N_REQ: one-hot or zero; the grant to requester i.
- rsp_valid  out  1: response held.
- rsp_ready  in  1: consumer accepts the response.
- rsp_id  out  IDW: index of the requester that owns the response.
- rsp_g  out  1: A > B.
- rsp_e  out  1: A == B.
- rsp_l  out  1: A < B.
- cmp_count  out  16: count of completed responses, saturates at 16'hFFFF.

## Operation
- FSM has three states: IDLE, CMP, RESP. Reset state is IDLE.
- **IDLE**
  - The winner is the first i with req_valid[i]=1, scanning upward from rr_ptr and wrapping modulo N_REQ.
  - req_ready[winner]=1 (combinational). All other req_ready bits are 0.
  - When any req_valid is set: latch the winner's A, B and ID on the clock edge, and set rr_ptr = (winner+1) mod N_REQ. Then go to CMP.
  - When no req_valid is set: stay in IDLE. rr_ptr is unchanged.
- **CMP**
  - req_ready = 0.
  - Compute G/E/L from the latched operands as unsigned values. Exactly one flag is 1.
  - Register the flags and the ID into the rsp_* outputs. Go to RESP.
- **RESP**
  - rsp_valid = 1 and req_ready = 0.
  - When rsp_ready=1 on an edge: clear rsp_valid, increment cmp_count with saturation, and go to IDLE.
  - rsp_g, rsp_e, rsp_l and rsp_id stay stable for the whole time rsp_valid=1, and keep their last values after rsp_valid drops.
- Requester rules:
  - A requester holds req_valid, req_a and req_b stable until it sees req_ready.
  - A requester may drop req_valid before it is granted. That is legal, and the request is simply not arbitrated.
- A requester is granted no more than once per N_REQ grants while other requesters stay valid, so no requester starves.

## Timing
- Reset values (while rst_n=0, applied asynchronously):
  - state = IDLE, rr_ptr = 0.
  - rsp_valid = 0, rsp_g = rsp_e = rsp_l = 0, rsp_id = 0, cmp_count = 0.
  - req_ready = 0. It is forced low for the whole time rst_n is low.
- Acceptance happens at edge k when req_valid[i] & req_ready[i] are both 1.
- rsp_valid goes high after edge k+1. This is a fixed latency of 1 cycle.
- Handshake completion at edge m (rsp_valid & rsp_ready) puts the FSM back in IDLE after edge m. The earliest next acceptance is edge m+1.
- Peak throughput is one compare per 3 cycles when rsp_ready is tied high.
- Reset mid-operation (in CMP or RESP) abandons the transaction. No response is produced and cmp_count does not increment.
- The FSM never leaves RESP while rsp_ready stays 0. There is no timeout.
- rr_ptr wraps from N_REQ-1 to 0.
- If one requester is the only valid one, it is granted on every pass through IDLE, whatever the value of rr_ptr.

## Test plan
- **Basic compare.** Reset. Requester 0 presents A=4'b0101, B=4'b0011. rsp_ready=1.
  - Required: req_ready[0] is high in the first IDLE cycle.
  - Required: rsp_valid is high one cycle after acceptance, with rsp_id=0 and G=1, E=0, L=0.
  - Required: cmp_count=1.
- **All three outcomes.** Requester 2 sends 4'b1111/4'b1111, then 4'b0010/4'b1000, then 4'b1110/4'b1101.
  - Required: the responses are E, L and G respectively, each with rsp_id=2.
  - Required: exactly one flag is set in each response.
- **Round-robin order.** All 4 requesters are valid continuously with distinct pairs.
  - Required: the grant order is 0, 1, 2, 3, 0, ...
  - Required: each response carries the matching rsp_id and the correct flags for that requester's pair.
- **Back-pressure.** rsp_ready is held 0 for 5 cycles after rsp_valid rises, with A=4'b1010, B=4'b1011.
  - Required: rsp_valid, rsp_l=1 and rsp_id stay stable for those 5 cycles.
  - Required: req_ready stays all-zero.
  - Required: the handshake completes on the first cycle rsp_ready=1.
- **Reset mid-operation.** Deassert rst_n while in RESP, with rsp_id=1.
  - Required: all outputs go to their reset values immediately, before the next clock edge.
  - Required: after release, cmp_count=0 and the first grant goes to the lowest valid index.
- **Saturation.** Force cmp_count to 16'hFFFE, then complete 3 responses.
  - Required: cmp_count reads 16'hFFFF and holds there.

Source files
------------

// File: rtl/comp_share_arb.sv
// comp_share_arb
//   Shares one registered WIDTH-bit unsigned magnitude comparator among
//   N_REQ requesters. A round-robin arbiter picks one valid requester in
//   IDLE, latches its operand pair, compares it in CMP and holds the
//   one-hot G/E/L result plus requester ID in RESP until the consumer
//   accepts it.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester valid (N_REQ)
//   req_a      : packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      : packed operand B, same packing
//   req_ready  : one-hot grant (or zero), combinational in IDLE only
//   rsp_valid  : response held
//   rsp_ready  : consumer accepts the response
//   rsp_id     : requester index owning the response
//   rsp_g/e/l  : A > B, A == B, A < B (exactly one set per response)
//   cmp_count  : completed responses, saturating at 16'hFFFF
module comp_share_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_g,
  output logic                   rsp_e,
  output logic                   rsp_l,
  output logic [15:0]            cmp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               rsp_g_q, rsp_g_d;
  logic               rsp_e_q, rsp_e_d;
  logic               rsp_l_q, rsp_l_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic               accept;
  logic               rsp_done;

  // Round-robin scan: first valid index at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_a     = '0;
    win_b     = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
        win_a     = req_a[idx*WIDTH +: WIDTH];
        win_b     = req_b[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign accept   = (state_q == IDLE) && win_found;
  assign rsp_done = (state_q == RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = CMP;
      CMP:     state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; the grant is gated by rst_n so it stays low throughout reset
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && win_found) begin
          req_ready = N_REQ'(1) << win_idx;
        end
      end
      RESP:    rsp_valid = 1'b1;
      default: begin
        req_ready = '0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    rsp_id_d = rsp_id_q;
    rsp_g_d  = rsp_g_q;
    rsp_e_d  = rsp_e_q;
    rsp_l_d  = rsp_l_q;
    cnt_d    = cnt_q;

    if (accept) begin
      a_d      = win_a;
      b_d      = win_b;
      id_d     = win_idx;
      rr_ptr_d = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    if (state_q == CMP) begin
      rsp_g_d  = (a_q >  b_q);
      rsp_e_d  = (a_q == b_q);
      rsp_l_d  = (a_q <  b_q);
      rsp_id_d = id_q;
    end

    if (rsp_done && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
      rsp_g_q  <= 1'b0;
      rsp_e_q  <= 1'b0;
      rsp_l_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      rsp_g_q  <= rsp_g_d;
      rsp_e_q  <= rsp_e_d;
      rsp_l_q  <= rsp_l_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rsp_id    = rsp_id_q;
  assign rsp_g     = rsp_g_q;
  assign rsp_e     = rsp_e_q;
  assign rsp_l     = rsp_l_q;
  assign cmp_count = cnt_q;

endmodule
